// File: rtl/ecap5_wbuart_fifo.sv
// Wishbone UART with RX/TX FIFOs, programmable RX threshold and level interrupt.

// Circular buffer with an extra pointer bit to tell full from empty.
module ecap5_wbuart_fifo_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot a push into a full buffer needs.
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer advance
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Pointer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage, no reset needed
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end
endmodule

module ecap5_wbuart_fifo #(
  parameter int unsigned RX_DEPTH      = 16,
  parameter int unsigned TX_DEPTH      = 16,
  parameter int unsigned CLK_DIV_RESET = 434
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_adr_i,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  input  logic        wb_cyc_i,
  output logic        wb_stall_o,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic        irq_o
);
  localparam int unsigned RXAW = $clog2(RX_DEPTH);
  localparam int unsigned TXAW = $clog2(TX_DEPTH);
  localparam logic [31:0] CR_MASK = 32'hFFFF_FF0F;
  localparam logic [2:0] A_CR   = 3'd0;
  localparam logic [2:0] A_SR   = 3'd1;
  localparam logic [2:0] A_RXDR = 3'd2;
  localparam logic [2:0] A_TXDR = 3'd3;
  localparam logic [2:0] A_IER  = 3'd4;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_e;

  // Bus decode
  logic       acc_c, rd_c, wr_c;
  logic [2:0] reg_c;
  logic       unused_adr;
  assign acc_c      = wb_cyc_i & wb_stb_i;
  assign rd_c       = acc_c & ~wb_we_i;
  assign wr_c       = acc_c & wb_we_i;
  assign reg_c      = wb_adr_i[4:2];
  assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

  // Control register and derived frame configuration
  logic [31:0] cr_q;
  logic [3:0]  ier_q;
  logic        cr_ds, cr_s, cr_par_en, cr_odd;
  logic [7:0]  cr_thr;
  logic [15:0] div_eff;
  assign cr_ds     = cr_q[0];
  assign cr_s      = cr_q[1];
  assign cr_par_en = cr_q[3] ^ cr_q[2];
  assign cr_odd    = cr_q[3];
  assign cr_thr    = cr_q[15:8];
  assign div_eff   = (cr_q[31:16] == 16'd0) ? 16'd1 : cr_q[31:16];

  // FIFOs
  logic          rx_push_c, rx_pop_c, rx_empty, rx_full;
  logic [9:0]    rx_push_data, rx_head;
  logic [RXAW:0] rx_level;
  logic          tx_push_c, tx_pop_c, tx_empty, tx_full;
  logic [7:0]    tx_head;
  logic [TXAW:0] tx_level;

  ecap5_wbuart_fifo_buf #(.DEPTH(RX_DEPTH), .WIDTH(10)) u_rx_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(rx_push_c), .data_i(rx_push_data),
    .pop_i(rx_pop_c), .data_o(rx_head), .empty_o(rx_empty), .full_o(rx_full),
    .level_o(rx_level)
  );

  ecap5_wbuart_fifo_buf #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(tx_push_c), .data_i(wb_dat_i[7:0]),
    .pop_i(tx_pop_c), .data_o(tx_head), .empty_o(tx_empty), .full_o(tx_full),
    .level_o(tx_level)
  );

  assign rx_pop_c  = rd_c & (reg_c == A_RXDR) & ~rx_empty;
  assign tx_push_c = wr_c & (reg_c == A_TXDR);

  // ---------------- TX engine ----------------
  uart_state_e tx_state_q;
  logic [15:0] tx_cnt_q, tx_div_q;
  logic [7:0]  tx_sh_q;
  logic [2:0]  tx_bit_q;
  logic        tx_ds_q, tx_two_q, tx_par_en_q, tx_par_q, tx_stop2_q, tx_q;
  logic        tx_end_c, tx_start_c, txe_c;

  assign tx_end_c   = (tx_cnt_q == tx_div_q - 16'd1);
  assign tx_start_c = ~tx_empty & ((tx_state_q == S_IDLE) |
                      ((tx_state_q == S_STOP) & tx_end_c & ~tx_stop2_q));
  assign tx_pop_c   = tx_start_c;
  assign txe_c      = tx_empty & (tx_state_q == S_IDLE);

  // Transmit shifter; a new frame starts straight out of STOP when data is waiting
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state_q  <= S_IDLE;
      tx_cnt_q    <= 16'd0;
      tx_div_q    <= 16'd1;
      tx_sh_q     <= 8'd0;
      tx_bit_q    <= 3'd0;
      tx_ds_q     <= 1'b0;
      tx_two_q    <= 1'b0;
      tx_par_en_q <= 1'b0;
      tx_par_q    <= 1'b0;
      tx_stop2_q  <= 1'b0;
      tx_q        <= 1'b1;
    end else if (tx_start_c) begin
      tx_state_q  <= S_START;
      tx_cnt_q    <= 16'd0;
      tx_div_q    <= div_eff;
      tx_sh_q     <= tx_head;
      tx_ds_q     <= cr_ds;
      tx_two_q    <= cr_s;
      tx_par_en_q <= cr_par_en;
      tx_par_q    <= (^(tx_head & {~cr_ds, 7'h7F})) ^ cr_odd;
      tx_stop2_q  <= 1'b0;
      tx_q        <= 1'b0;
    end else begin
      case (tx_state_q)
        S_START: begin
          if (tx_end_c) begin
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 3'd0;
            tx_state_q <= S_DATA;
            tx_q       <= tx_sh_q[0];
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        S_DATA: begin
          if (tx_end_c) begin
            tx_cnt_q <= 16'd0;
            tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
            if (tx_bit_q == (tx_ds_q ? 3'd6 : 3'd7)) begin
              if (tx_par_en_q) begin
                tx_state_q <= S_PARITY;
                tx_q       <= tx_par_q;
              end else begin
                tx_state_q <= S_STOP;
                tx_stop2_q <= tx_two_q;
                tx_q       <= 1'b1;
              end
            end else begin
              tx_bit_q <= tx_bit_q + 3'd1;
              tx_q     <= tx_sh_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        S_PARITY: begin
          if (tx_end_c) begin
            tx_cnt_q   <= 16'd0;
            tx_state_q <= S_STOP;
            tx_stop2_q <= tx_two_q;
            tx_q       <= 1'b1;
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        S_STOP: begin
          if (tx_end_c) begin
            tx_cnt_q <= 16'd0;
            if (tx_stop2_q) tx_stop2_q <= 1'b0;
            else            tx_state_q <= S_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        default: begin
          tx_cnt_q <= 16'd0;
          tx_q     <= 1'b1;
        end
      endcase
    end
  end

  // ---------------- RX engine ----------------
  uart_state_e rx_state_q;
  logic [15:0] rx_cnt_q, rx_div_q;
  logic [7:0]  rx_sh_q;
  logic [2:0]  rx_bit_q;
  logic        rx_ds_q, rx_par_en_q, rx_odd_q, rx_acc_q, rx_perr_q;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic        rx_hit_c;

  // START is re-checked at half a bit, every later sample is one full bit apart
  assign rx_hit_c     = (rx_cnt_q == ((rx_state_q == S_START) ? {1'b0, rx_div_q[15:1]}
                                                              : rx_div_q - 16'd1));
  assign rx_push_c    = (rx_state_q == S_STOP) & rx_hit_c;
  assign rx_push_data = {~rx_sync_q, rx_perr_q, rx_sh_q};

  // Synchroniser and receive sampler
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= S_IDLE;
      rx_cnt_q    <= 16'd0;
      rx_div_q    <= 16'd1;
      rx_sh_q     <= 8'd0;
      rx_bit_q    <= 3'd0;
      rx_ds_q     <= 1'b0;
      rx_par_en_q <= 1'b0;
      rx_odd_q    <= 1'b0;
      rx_acc_q    <= 1'b0;
      rx_perr_q   <= 1'b0;
    end else begin
      rx_meta_q <= uart_rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      case (rx_state_q)
        S_IDLE: begin
          if (rx_prev_q & ~rx_sync_q) begin
            rx_state_q  <= S_START;
            rx_cnt_q    <= 16'd0;
            rx_div_q    <= div_eff;
            rx_ds_q     <= cr_ds;
            rx_par_en_q <= cr_par_en;
            rx_odd_q    <= cr_odd;
            rx_sh_q     <= 8'd0;
            rx_bit_q    <= 3'd0;
            rx_acc_q    <= 1'b0;
            rx_perr_q   <= 1'b0;
          end
        end
        S_START: begin
          if (rx_hit_c) begin
            rx_cnt_q   <= 16'd0;
            rx_state_q <= rx_sync_q ? S_IDLE : S_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        S_DATA: begin
          if (rx_hit_c) begin
            rx_cnt_q          <= 16'd0;
            rx_sh_q[rx_bit_q] <= rx_sync_q;
            rx_acc_q          <= rx_acc_q ^ rx_sync_q;
            if (rx_bit_q == (rx_ds_q ? 3'd6 : 3'd7))
              rx_state_q <= rx_par_en_q ? S_PARITY : S_STOP;
            else
              rx_bit_q <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        S_PARITY: begin
          if (rx_hit_c) begin
            rx_cnt_q   <= 16'd0;
            rx_perr_q  <= rx_sync_q ^ rx_acc_q ^ rx_odd_q;
            rx_state_q <= S_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        S_STOP: begin
          if (rx_hit_c) begin
            rx_cnt_q   <= 16'd0;
            rx_state_q <= S_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------- Status, registers, bus ----------------
  logic        rxoe_q, fe_q, pe_q, txoe_q;
  logic        sr_clr_c, rxthr_c;
  logic [31:0] sr_c, rdata_c;
  logic        ack_q, irq_q;
  logic [31:0] dat_q;

  assign sr_clr_c = rd_c & (reg_c == A_SR);
  assign rxthr_c  = (cr_thr != 8'd0) && (9'(rx_level) >= {1'b0, cr_thr});
  assign sr_c     = {8'h00, 8'(tx_level), 8'(rx_level), rxthr_c, txoe_q, pe_q, fe_q,
                     rxoe_q, ~tx_full, txe_c, ~rx_empty};

  // Read data mux
  always_comb begin
    rdata_c = 32'h0;
    case (reg_c)
      A_CR:    rdata_c = cr_q;
      A_SR:    rdata_c = sr_c;
      A_RXDR:  rdata_c = rx_empty ? 32'h0 : {22'h0, rx_head};
      A_IER:   rdata_c = {28'h0, ier_q};
      default: rdata_c = 32'h0;
    endcase
  end

  // Config registers, sticky flags, bus response and interrupt
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cr_q   <= {16'(CLK_DIV_RESET), 16'h0000};
      ier_q  <= 4'h0;
      rxoe_q <= 1'b0;
      fe_q   <= 1'b0;
      pe_q   <= 1'b0;
      txoe_q <= 1'b0;
      ack_q  <= 1'b0;
      dat_q  <= 32'h0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_c && reg_c == A_CR) begin
        for (int b = 0; b < 4; b++)
          if (wb_sel_i[b]) cr_q[b*8 +: 8] <= wb_dat_i[b*8 +: 8] & CR_MASK[b*8 +: 8];
      end
      if (wr_c && reg_c == A_IER && wb_sel_i[0]) ier_q <= wb_dat_i[3:0];
      rxoe_q <= (rxoe_q & ~sr_clr_c) | (rx_push_c & rx_full & ~rx_pop_c);
      fe_q   <= (fe_q   & ~sr_clr_c) | (rx_push_c & ~rx_sync_q);
      pe_q   <= (pe_q   & ~sr_clr_c) | (rx_push_c & rx_perr_q);
      txoe_q <= (txoe_q & ~sr_clr_c) | (tx_push_c & tx_full & ~tx_pop_c);
      ack_q  <= acc_c;
      dat_q  <= rd_c ? rdata_c : 32'h0;
      irq_q  <= (ier_q[0] & ~rx_empty) | (ier_q[1] & rxthr_c) | (ier_q[2] & txe_c) |
                (ier_q[3] & (rxoe_q | fe_q | pe_q | txoe_q));
    end
  end

  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;
  assign wb_stall_o = 1'b0;
  assign uart_tx_o  = tx_q;
  assign irq_o      = irq_q;
endmodule

// File: tb/tb_ecap5_wbuart_fifo.sv
// Directed bench for ecap5_wbuart_fifo (RX_DEPTH=4, 8-cycle bit period).
module tb_ecap5_wbuart_fifo;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] wb_adr_i = 32'h0;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = 32'h0;
  logic        wb_we_i = 1'b0;
  logic [3:0]  wb_sel_i = 4'h0;
  logic        wb_stb_i = 1'b0;
  logic        wb_ack_o;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stall_o;
  logic        uart_rx_i = 1'b1;
  logic        uart_tx_o;
  logic        irq_o;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] CR = 32'h0, SR = 32'h4, RXDR = 32'h8, TXDR = 32'hC, IER = 32'h10;

  ecap5_wbuart_fifo #(.RX_DEPTH(4), .TX_DEPTH(16), .CLK_DIV_RESET(434)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wb_adr_i(wb_adr_i), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i),
    .wb_ack_o(wb_ack_o), .wb_cyc_i(wb_cyc_i), .wb_stall_o(wb_stall_o),
    .uart_rx_i(uart_rx_i), .uart_tx_o(uart_tx_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One bus access, called and returning on a falling edge
  task automatic wb_access(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                           input logic [3:0] sel, output logic [31:0] rdat);
    wb_adr_i = adr; wb_we_i = we; wb_dat_i = wdat; wb_sel_i = sel;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk_i);
    #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(negedge clk_i);
    check("ack", {31'h0, wb_ack_o}, 32'h1);
    rdat = wb_dat_o;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] wdat);
    logic [31:0] dummy;
    wb_access(adr, 1'b1, wdat, 4'hF, dummy);
  endtask

  task automatic wb_check(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] rd;
    wb_access(adr, 1'b0, 32'h0, 4'hF, rd);
    check(tag, rd, exp);
  endtask

  task automatic send_bit(input logic b);
    uart_rx_i = b;
    repeat (8) @(negedge clk_i);
  endtask

  // par < 0 means no parity bit
  task automatic uart_send(input logic [7:0] d, input int par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (par >= 0) send_bit(par[0]);
    send_bit(1'b1);
    repeat (4) @(negedge clk_i);
  endtask

  task automatic wait_tx_start(input string tag);
    int k = 0;
    while (uart_tx_o !== 1'b0 && k < 100) begin
      @(negedge clk_i);
      k++;
    end
    if (k >= 100) check(tag, 32'h1, 32'h0);
  endtask

  logic [7:0] tx_bytes [2];
  logic [7:0] rx_bytes [5];
  logic [9:0] frame;
  logic [7:0] samp;
  int         falls;
  logic       prev;

  initial begin
    tx_bytes = '{8'h55, 8'hA3};
    rx_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    // Reset state
    repeat (4) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_ack", {31'h0, wb_ack_o}, 32'h0);
    check("rst_dat", wb_dat_o, 32'h0);
    check("rst_tx", {31'h0, uart_tx_o}, 32'h1);
    check("rst_irq", {31'h0, irq_o}, 32'h0);
    wb_check("rst_cr", CR, 32'h01B2_0000);
    wb_check("rst_sr", SR, 32'h0000_0006);

    // Byte-selected CR write: only upper half lands, clk_div = 8
    begin
      logic [31:0] dummy;
      wb_access(CR, 1'b1, 32'h0008_FFFF, 4'b1100, dummy);
    end
    wb_check("cr_sel", CR, 32'h0008_0000);

    // Two back-to-back 8N1 frames
    wb_write(TXDR, 32'h0000_0055);
    wb_write(TXDR, 32'h0000_00A3);
    wait_tx_start("tx_start_timeout");
    for (int f = 0; f < 2; f++) begin
      frame = {1'b1, tx_bytes[f], 1'b0};
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < 8; c++) begin
          samp[c] = uart_tx_o;
          @(negedge clk_i);
        end
        check($sformatf("tx_f%0d_bit%0d", f, b), {24'h0, samp}, frame[b] ? 32'hFF : 32'h00);
      end
    end
    check("tx_idle", {31'h0, uart_tx_o}, 32'h1);
    wb_check("tx_done_sr", SR, 32'h0000_0006);

    // Even parity: good frame then bad parity bit
    wb_write(CR, 32'h0008_0004);
    uart_send(8'h5A, 0);
    uart_send(8'h5A, 1);
    wb_check("rx_par_ok", RXDR, 32'h0000_005A);
    wb_check("rx_par_bad", RXDR, 32'h0000_015A);
    wb_check("sr_pe_set", SR, 32'h0000_0026);
    wb_check("sr_pe_clr", SR, 32'h0000_0006);

    // Overrun: five frames into a four-entry FIFO
    wb_write(CR, 32'h0008_0000);
    for (int i = 0; i < 5; i++) uart_send(rx_bytes[i], -1);
    wb_check("ovr_sr", SR, 32'h0000_040F);
    for (int i = 0; i < 4; i++) wb_check($sformatf("ovr_rx%0d", i), RXDR, {24'h0, rx_bytes[i]});
    wb_check("rx_empty_read", RXDR, 32'h0);
    wb_check("ovr_sr_clr", SR, 32'h0000_0006);

    // Threshold interrupt
    wb_write(CR, 32'h0008_0300);
    wb_write(IER, 32'h0000_0002);
    uart_send(8'h01, -1);
    uart_send(8'h02, -1);
    check("irq_below_thr", {31'h0, irq_o}, 32'h0);
    uart_send(8'h03, -1);
    check("irq_at_thr", {31'h0, irq_o}, 32'h1);
    wb_check("thr_sr", SR, 32'h0000_0387);
    wb_check("thr_rx0", RXDR, 32'h0000_0001);
    check("irq_hold", {31'h0, irq_o}, 32'h1);
    @(negedge clk_i);
    check("irq_fall", {31'h0, irq_o}, 32'h0);

    // Reset in the middle of data bit 3
    wb_write(CR, 32'h0008_0000);
    wb_write(TXDR, 32'h0000_0055);
    wb_write(TXDR, 32'h0000_00A3);
    wait_tx_start("tx2_start_timeout");
    repeat (36) @(negedge clk_i);
    check("mid_bit3", {31'h0, uart_tx_o}, 32'h0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_mid_tx", {31'h0, uart_tx_o}, 32'h1);
    falls = 0;
    prev  = uart_tx_o;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (uart_tx_o !== prev) falls++;
      prev = uart_tx_o;
    end
    check("no_edges_after_rst", falls, 32'h0);
    check("irq_after_rst", {31'h0, irq_o}, 32'h0);
    wb_check("sr_after_rst", SR, 32'h0000_0006);
    wb_check("cr_after_rst", CR, 32'h01B2_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
